instr_prefetch_unit: RTL and testbench



---
 rtl/instr_prefetch_unit_if.sv | 24 ++
 rtl/instr_prefetch_unit.sv | 169 ++++++++++++++++
 tb/tb_instr_prefetch_unit.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_prefetch_unit_if.sv
// Memory-side req/gnt/rvalid fetch bus between the prefetch unit (master) and instruction memory (slave).
interface instr_prefetch_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_gnt,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_gnt,
    output mem_rvalid,
    output mem_rdata
  );
endinterface

// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch front end: credit-limited fetch, DEPTH-entry word/PC FIFO, redirect with stale-response discard.
// Optional PREFETCH_PERF_EN adds saturating perf_flushes / perf_dropped / perf_starve counters.
module instr_prefetch_unit #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'd0,
  parameter logic [31:0] PC_STEP         = 32'd2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  instr_prefetch_unit_if.master mem_bus
`ifdef PREFETCH_PERF_EN
  ,
  output logic [31:0] perf_flushes,
  output logic [31:0] perf_dropped,
  output logic [31:0] perf_starve
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  state_e           state, state_nxt;
  logic [31:0]      fetch_pc, fetch_pc_nxt;
  logic [OUT_W-1:0] outstanding, outstanding_nxt;
  logic [OUT_W-1:0] discard_cnt, discard_nxt;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt, wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0] pq_rd, pq_wr;
  logic [CNT_W-1:0] count, count_nxt;
  logic [31:0]      fifo_data [DEPTH];
  logic [31:0]      fifo_pc   [DEPTH];
  logic [31:0]      pq_pc     [DEPTH];

  logic             mem_req_q, mem_req_nxt;
  logic [31:0]      mem_addr_q, mem_addr_nxt;
  logic             instr_valid_nxt;
  logic [31:0]      instr_nxt, instr_pc_nxt;
  logic             grant, resp, push, pop, credit_ok, head_is_push;
  logic [31:0]      resp_pc;

  assign mem_bus.mem_req  = mem_req_q;
  assign mem_bus.mem_addr = mem_addr_q;

  // Responses with nothing outstanding are protocol errors and are ignored entirely.
  assign grant   = mem_req_q & mem_bus.mem_gnt;
  assign resp    = mem_bus.mem_rvalid & (outstanding != '0);
  assign resp_pc = pq_pc[pq_rd];
  assign pop     = instr_valid & instr_ready & ~redirect;
  assign push    = resp & (discard_cnt == '0) & ~redirect;

  // Datapath next values; redirect overrides everything and clears the FIFO.
  always_comb begin
    outstanding_nxt = outstanding + OUT_W'(grant) - OUT_W'(resp);
    fetch_pc_nxt    = fetch_pc;
    discard_nxt     = discard_cnt;
    rd_ptr_nxt      = rd_ptr + PTR_W'(pop);
    wr_ptr_nxt      = wr_ptr + PTR_W'(push);
    count_nxt       = count + CNT_W'(push) - CNT_W'(pop);
    if (grant) fetch_pc_nxt = fetch_pc + PC_STEP;
    if (resp && (discard_cnt != '0)) discard_nxt = discard_cnt - OUT_W'(1);
    if (redirect) begin
      fetch_pc_nxt = redirect_pc;
      discard_nxt  = outstanding_nxt;
      rd_ptr_nxt   = '0;
      wr_ptr_nxt   = '0;
      count_nxt    = '0;
    end
    credit_ok = ((32'(outstanding_nxt) + 32'(count_nxt)) < DEPTH) &&
                (32'(outstanding_nxt) < MAX_OUTSTANDING);
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect)                                   state_nxt = (outstanding_nxt != '0) ? FLUSH : RUN;
    else if ((state == FLUSH) && (discard_nxt == '0)) state_nxt = RUN;
  end

  // Registered-output next values; a word pushed into an empty (or draining) FIFO becomes the head directly.
  always_comb begin
    mem_req_nxt     = 1'b0;
    mem_addr_nxt    = fetch_pc_nxt;
    instr_valid_nxt = (count_nxt != '0);
    instr_nxt       = instr;
    instr_pc_nxt    = instr_pc;
    head_is_push    = push && (count == CNT_W'(pop));
    if ((state_nxt == RUN) && !redirect && credit_ok) mem_req_nxt = 1'b1;
    if (head_is_push) begin
      instr_nxt    = mem_bus.mem_rdata;
      instr_pc_nxt = resp_pc;
    end else if (!redirect && (count_nxt != '0)) begin
      instr_nxt    = fifo_data[rd_ptr_nxt];
      instr_pc_nxt = fifo_pc[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      pq_rd       <= '0;
      pq_wr       <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      fetch_pc    <= fetch_pc_nxt;
      outstanding <= outstanding_nxt;
      discard_cnt <= discard_nxt;
      rd_ptr      <= rd_ptr_nxt;
      wr_ptr      <= wr_ptr_nxt;
      count       <= count_nxt;
      if (grant) pq_wr <= pq_wr + PTR_W'(1);
      if (resp)  pq_rd <= pq_rd + PTR_W'(1);
      mem_req_q   <= mem_req_nxt;
      mem_addr_q  <= mem_addr_nxt;
      instr_valid <= instr_valid_nxt;
      instr       <= instr_nxt;
      instr_pc    <= instr_pc_nxt;
    end
  end

  // Storage arrays: FIFO payload and the PC of every granted-but-unanswered request.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem_bus.mem_rdata;
      fifo_pc[wr_ptr]   <= resp_pc;
    end
    if (grant) pq_pc[pq_wr] <= fetch_pc;
  end

`ifdef PREFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_flushes <= '0;
      perf_dropped <= '0;
      perf_starve  <= '0;
    end else begin
      if (redirect && (perf_flushes != '1)) perf_flushes <= perf_flushes + 32'd1;
      if (resp && (redirect || (discard_cnt != '0)) && (perf_dropped != '1))
        perf_dropped <= perf_dropped + 32'd1;
      if (!instr_valid && (perf_starve != '1)) perf_starve <= perf_starve + 32'd1;
    end
  end
`endif

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!reset)
    !(mem_bus.mem_rvalid && (outstanding == '0)));

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Scoreboard bench for instr_prefetch_unit: latency-programmable memory model, directed redirect/reset scenarios.
module tb_instr_prefetch_unit;
  logic        clk = 1'b0;
  logic        reset, redirect, instr_ready, instr_valid;
  logic [31:0] redirect_pc, instr, instr_pc;

  instr_prefetch_unit_if bus();

`ifdef PREFETCH_PERF_EN
  logic [31:0] perf_flushes, perf_dropped, perf_starve;
`endif

  instr_prefetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .mem_bus     (bus)
`ifdef PREFETCH_PERF_EN
    ,
    .perf_flushes(perf_flushes),
    .perf_dropped(perf_dropped),
    .perf_starve (perf_starve)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc = 0, lat = 1;
  int          grant_cnt = 0, rvalid_cnt = 0, max_pend = 0, pop_cnt = 0;
  pend_t       pend[$];
  logic [31:0] grant_log[$];
  logic [31:0] exp_q[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_restart(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(pc + 32'(2 * i));
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_stats();
    grant_cnt  = 0;
    rvalid_cnt = 0;
    max_pend   = 0;
    grant_log.delete();
  endtask

  task automatic pulse_reset(input int new_lat);
    next_cycle();
    reset = 1'b0;
    next_cycle();
    lat = new_lat;
    clear_stats();
    sb_restart(32'd0);
    reset = 1'b1;
  endtask

  // Memory: decides gnt/rvalid at each falling edge for the next rising edge; in-order, fixed latency.
  initial begin
    pend_t pe;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        pend.delete();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
      end else begin
        if ((pend.size() != 0) && (pend[0].due <= cyc)) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = word_of(pend[0].addr);
          void'(pend.pop_front());
          rvalid_cnt++;
        end else begin
          bus.mem_rvalid = 1'b0;
          bus.mem_rdata  = '0;
        end
        bus.mem_gnt = 1'b1;
        if (bus.mem_req) begin
          pe.addr = bus.mem_addr;
          pe.due  = cyc + lat;
          pend.push_back(pe);
          grant_log.push_back(bus.mem_addr);
          grant_cnt++;
        end
        if (pend.size() > max_pend) max_pend = pend.size();
      end
    end
  end

  // Monitor: every accepted head is compared against the expected stream.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (reset && instr_valid && instr_ready && !redirect) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: got pc %h with no expected entry", instr_pc);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", instr_pc, e);
          check("sb_instr", instr, word_of(e));
        end
      end
    end
  end

  task automatic redirect_check(input logic [31:0] pc, input int exp_drops);
    int rv0, g0, p0;
    bit seen;
    redirect    = 1'b1;
    redirect_pc = pc;
    sb_restart(pc);
    rv0 = rvalid_cnt;
    g0  = grant_cnt;
    next_cycle();
    redirect = 1'b0;
    check("redir_req_drop", 32'(bus.mem_req), 32'd0);
    check("redir_valid_clr", 32'(instr_valid), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      if (bus.mem_req) begin
        seen = 1'b1;
        break;
      end
    end
    check("redir_restart_seen", 32'(seen), 32'd1);
    check("redir_dropped", 32'(rvalid_cnt - rv0), 32'(exp_drops));
    check("redir_grants_in_flush", 32'(grant_cnt - g0), 32'd1);
    check("redir_addr", bus.mem_addr, pc);
    p0 = pop_cnt;
    repeat (15) next_cycle();
    check("redir_delivers", 32'(pop_cnt - p0 != 0), 32'd1);
  endtask

  initial begin
    int first, p0;
    bit found;
    reset       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;

    // Reset values.
    repeat (3) next_cycle();
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);

    // 1-cycle memory, always granted, core always ready.
    lat = 1;
    clear_stats();
    sb_restart(32'd0);
    instr_ready = 1'b1;
    reset       = 1'b1;
    first       = 99;
    for (int k = 1; k <= 20; k++) begin
      next_cycle();
      if (instr_valid) begin
        first = k;
        break;
      end
    end
    check("first_valid_latency", 32'(first), 32'd3);
    repeat (8) next_cycle();
    check("addr0", grant_log[0], 32'd0);
    check("addr1", grant_log[1], 32'd2);
    check("addr2", grant_log[2], 32'd4);
    check("addr3", grant_log[3], 32'd6);

    // Core stalled: FIFO fills after exactly DEPTH grants; one pop frees one credit.
    instr_ready = 1'b0;
    pulse_reset(1);
    repeat (15) next_cycle();
    check("full_grants", 32'(grant_cnt), 32'd4);
    check("full_req_off", 32'(bus.mem_req), 32'd0);
    check("full_valid", 32'(instr_valid), 32'd1);
    check("full_head_pc", instr_pc, 32'd0);
    check("full_head_instr", instr, word_of(32'd0));
    instr_ready = 1'b1;
    next_cycle();
    instr_ready = 1'b0;
    repeat (10) next_cycle();
    check("one_pop_one_grant", 32'(grant_cnt), 32'd5);
    check("refill_req_off", 32'(bus.mem_req), 32'd0);

    // 2-edge memory latency: outstanding limit caps throughput at 2 words per 3 cycles.
    instr_ready = 1'b1;
    pulse_reset(2);
    repeat (20) next_cycle();
    p0 = pop_cnt;
    repeat (30) next_cycle();
    check("throughput_30cyc", 32'(pop_cnt - p0), 32'd20);
    check("max_outstanding", 32'(max_pend), 32'd2);

    // Redirect with two responses in flight and no grant/response on the redirect edge.
    pulse_reset(3);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      next_cycle();
      if ((pend.size() == 2) && !bus.mem_rvalid && !(bus.mem_req && bus.mem_gnt)) begin
        found = 1'b1;
        break;
      end
    end
    check("redir2_setup", 32'(found), 32'd1);
    redirect_check(32'h40, 2);

    // Redirect on an edge carrying both a grant and a response.
    pulse_reset(1);
    repeat (8) next_cycle();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.mem_rvalid && bus.mem_req && bus.mem_gnt) begin
        found = 1'b1;
        break;
      end
      next_cycle();
    end
    check("redir_gnt_rv_setup", 32'(found), 32'd1);
    redirect_check(32'h100, 1);

    // Reset pulse mid-burst with two outstanding.
    pulse_reset(3);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      next_cycle();
      if (pend.size() == 2) begin
        found = 1'b1;
        break;
      end
    end
    check("midrst_setup", 32'(found), 32'd1);
    reset = 1'b0;
    next_cycle();
    check("midrst_mem_req", 32'(bus.mem_req), 32'd0);
    check("midrst_mem_addr", bus.mem_addr, 32'd0);
    check("midrst_instr_valid", 32'(instr_valid), 32'd0);
    check("midrst_instr", instr, 32'd0);
    check("midrst_instr_pc", instr_pc, 32'd0);
    clear_stats();
    sb_restart(32'd0);
    reset = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      if (bus.mem_req) begin
        found = 1'b1;
        break;
      end
    end
    check("midrst_restart_seen", 32'(found), 32'd1);
    check("midrst_restart_addr", bus.mem_addr, 32'd0);
    p0 = pop_cnt;
    repeat (20) next_cycle();
    check("midrst_delivers", 32'(pop_cnt - p0 != 0), 32'd1);

`ifdef PREFETCH_PERF_EN
    check("perf_flushes_after_rst", perf_flushes, 32'd0);
    check("perf_dropped_after_rst", perf_dropped, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
